// File: rtl/booth_mul4_pkg.sv
// Shared constants for the Booth multiplier: state encoding and operand/product widths.
package booth_mul4_pkg;
  localparam int W  = 4;
  localparam int PW = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/booth_mul4_if.sv
// Start/done request bus between a requester and the Booth multiplier.
interface booth_mul4_if;
  import booth_mul4_pkg::*;

  logic          start;
  logic [W-1:0]  multiplicand;
  logic [W-1:0]  multiplier;
  logic          busy;
  logic          done;
  logic [PW-1:0] product;

  modport master (output start, multiplicand, multiplier, input busy, done, product);
  modport slave  (input start, multiplicand, multiplier, output busy, done, product);
endinterface

// File: rtl/booth_mul4_addsub.sv
// 4-bit add/subtract datapath: s = a + b (m=0) or a - b (m=1), v = signed overflow.
// Purely combinational, zero latency, no flow control.
module addsub
  import booth_mul4_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         m,
  output logic [W-1:0] s,
  output logic         v
);
  logic [W-1:0] b_eff;

  always_comb begin
    b_eff = m ? ~b : b;
    s     = a + b_eff + {{(W-1){1'b0}}, m};
    // Overflow when both effective operands share a sign the result does not.
    v     = (a[W-1] == b_eff[W-1]) && (s[W-1] != a[W-1]);
  end
endmodule

// File: rtl/booth_mul4.sv
// Radix-2 Booth 4x4 signed multiplier sequencer; done pulses 4 cycles after start is accepted.
// start is honoured only in IDLE; requests while busy are dropped.
module booth_mul4
  import booth_mul4_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  booth_mul4_if.slave  bus
);
  logic [1:0]   state;
  logic [1:0]   next_state;
  logic [W-1:0] a_reg;
  logic [W-1:0] q_reg;
  logic         q_m1;
  logic [W-1:0] m_reg;
  logic [1:0]   cnt;

  logic [W-1:0] as_s;
  logic         as_v;
  logic         do_op;
  logic [W-1:0] sum;
  logic         ts;

  addsub u_addsub (
    .a (a_reg),
    .b (m_reg),
    .m (q_reg[0]),
    .s (as_s),
    .v (as_v)
  );

  // Pair 10 subtracts, 01 adds (q_reg[0] is the mode); 00/11 pass A through.
  always_comb begin
    do_op = q_reg[0] ^ q_m1;
    sum   = do_op ? as_s : a_reg;
    // The overflow-corrected sign stands in for a fifth adder bit.
    ts    = sum[W-1] ^ (do_op & as_v);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = CALC;
      CALC:    if (cnt == 2'd3) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg       <= '0;
      q_reg       <= '0;
      q_m1        <= 1'b0;
      m_reg       <= '0;
      cnt         <= 2'd0;
      bus.product <= '0;
    end else if (state == IDLE && bus.start) begin
      a_reg <= '0;
      q_reg <= bus.multiplier;
      q_m1  <= 1'b0;
      m_reg <= bus.multiplicand;
      cnt   <= 2'd0;
    end else if (state == CALC) begin
      a_reg <= {ts, sum[W-1:1]};
      q_reg <= {sum[0], q_reg[W-1:1]};
      q_m1  <= q_reg[0];
      cnt   <= cnt + 2'd1;
      if (cnt == 2'd3)
        bus.product <= {ts, sum[W-1:1], sum[0], q_reg[W-1:1]};
    end
  end
endmodule
